// File: rtl/mips_pkg.sv
// Shared constants for the MIPS writeback path: unit indices and datapath widths.
// Also holds the round-robin successor helper used by the writeback arbiter.
package mips_pkg;
   localparam int UNIT_X     = 0;
   localparam int UNIT_Y     = 1;
   localparam int UNIT_M     = 2;
   localparam int NUM_UNITS  = 3;
   localparam int REG_ADDR_W = 5;
   localparam int WORD_W     = 32;

   function automatic logic [1:0] rr_next(input logic [1:0] u);
      return (u == 2'(UNIT_M)) ? 2'(UNIT_X) : u + 2'd1;
   endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small per-unit result FIFO; push is ignored when full, pop is ignored when empty.
// Storage is not reset: the empty flag alone makes stale entries invisible.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [W-1:0]           din_i,
   input  logic                   pop_i,
   output logic [W-1:0]           dout_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among units X, Y and M.
// Optional WB_STATS_EN adds saturating write / conflict counters.
module wb_arbiter
   import mips_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = WORD_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              x_wb_writereg,
   input  logic [ADDR_W-1:0] x_wb_regdest,
   input  logic [DATA_W-1:0] x_wb_wbvalue,
   output logic              x_ready,
   input  logic              y_wb_writereg,
   input  logic [ADDR_W-1:0] y_wb_regdest,
   input  logic [DATA_W-1:0] y_wb_wbvalue,
   output logic              y_ready,
   input  logic              m_wb_writereg,
   input  logic [ADDR_W-1:0] m_wb_regdest,
   input  logic [DATA_W-1:0] m_wb_wbvalue,
   output logic              m_ready,
`ifdef WB_STATS_EN
   output logic [CNT_W-1:0]  stat_writes,
   output logic [CNT_W-1:0]  stat_conflicts,
`endif
   output logic              wb_reg_en,
   output logic [ADDR_W-1:0] wb_reg_addr,
   output logic [DATA_W-1:0] wb_reg_data,
   output logic              is_stall
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = ADDR_W + DATA_W;

   logic [NUM_UNITS-1:0]             wr_v, rdy, push, pop, empty, full, near_full;
   logic [NUM_UNITS-1:0][ADDR_W-1:0] dest;
   logic [NUM_UNITS-1:0][DATA_W-1:0] val;
   logic [NUM_UNITS-1:0][EW-1:0]     head;
   logic [NUM_UNITS-1:0][CW-1:0]     cnt;

   logic [1:0]        rr_ptr_q, rr_ptr_d, grant, idx;
   logic              grant_vld;
   logic              wb_en_q, wb_en_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   assign wr_v = {m_wb_writereg, y_wb_writereg, x_wb_writereg};
   assign dest = {m_wb_regdest,  y_wb_regdest,  x_wb_regdest};
   assign val  = {m_wb_wbvalue,  y_wb_wbvalue,  x_wb_wbvalue};

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
      // r0 writes are acknowledged but never stored.
      assign rdy[u]       = ~full[u];
      assign push[u]      = wr_v[u] & rdy[u] & (dest[u] != '0);
      assign pop[u]       = grant_vld & (grant == 2'(u));
      assign near_full[u] = (cnt[u] >= CW'(DEPTH - 1));

      wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
         .clock   (clock),
         .reset   (reset),
         .push_i  (push[u]),
         .din_i   ({dest[u], val[u]}),
         .pop_i   (pop[u]),
         .dout_o  (head[u]),
         .count_o (cnt[u]),
         .full_o  (full[u]),
         .empty_o (empty[u])
      );
   end

   assign x_ready  = rdy[UNIT_X];
   assign y_ready  = rdy[UNIT_Y];
   assign m_ready  = rdy[UNIT_M];
   assign is_stall = |near_full;

   always_comb begin
      grant_vld = 1'b0;
      grant     = rr_ptr_q;
      idx       = rr_ptr_q;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (!grant_vld && !empty[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
         idx = rr_next(idx);
      end
   end

   always_comb begin
      wb_en_d   = grant_vld;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      rr_ptr_d  = rr_ptr_q;
      if (grant_vld) begin
         {wb_addr_d, wb_data_d} = head[grant];
         rr_ptr_d               = rr_next(grant);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q  <= 2'(UNIT_X);
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign wb_reg_en   = wb_en_q;
   assign wb_reg_addr = wb_addr_q;
   assign wb_reg_data = wb_data_q;

`ifdef WB_STATS_EN
   logic [CNT_W-1:0] stat_w_q, stat_c_q;
   logic             multi;

   assign multi = (~empty[0] & ~empty[1]) | (~empty[0] & ~empty[2]) | (~empty[1] & ~empty[2]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_w_q <= '0;
         stat_c_q <= '0;
      end else begin
         if (wb_en_q && stat_w_q != '1) stat_w_q <= stat_w_q + 1'b1;
         if (multi && stat_c_q != '1)   stat_c_q <= stat_c_q + 1'b1;
      end
   end

   assign stat_writes    = stat_w_q;
   assign stat_conflicts = stat_c_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter against a queue-based reference model.
// Build with WB_STATS_EN defined to also exercise the statistics counters.
module tb_wb_arbiter;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clock, reset;
   logic        x_wb_writereg, y_wb_writereg, m_wb_writereg;
   logic [4:0]  x_wb_regdest, y_wb_regdest, m_wb_regdest;
   logic [31:0] x_wb_wbvalue, y_wb_wbvalue, m_wb_wbvalue;
   logic        x_ready, y_ready, m_ready;
   logic        wb_reg_en, is_stall;
   logic [4:0]  wb_reg_addr;
   logic [31:0] wb_reg_data;
`ifdef WB_STATS_EN
   logic [15:0] stat_writes, stat_conflicts;
`endif

   wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
      .clock(clock), .reset(reset),
      .x_wb_writereg(x_wb_writereg), .x_wb_regdest(x_wb_regdest), .x_wb_wbvalue(x_wb_wbvalue), .x_ready(x_ready),
      .y_wb_writereg(y_wb_writereg), .y_wb_regdest(y_wb_regdest), .y_wb_wbvalue(y_wb_wbvalue), .y_ready(y_ready),
      .m_wb_writereg(m_wb_writereg), .m_wb_regdest(m_wb_regdest), .m_wb_wbvalue(m_wb_wbvalue), .m_ready(m_ready),
`ifdef WB_STATS_EN
      .stat_writes(stat_writes), .stat_conflicts(stat_conflicts),
`endif
      .wb_reg_en(wb_reg_en), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data), .is_stall(is_stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   ent_t mq [3][$];
   ent_t exp_q [$];
   int   rr;
   bit   exp_en;
   bit   stall_seen;
   int   tests, fails;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every write the DUT presents must match the oldest expected write.
   initial begin
      ent_t e;
      forever begin
         @(negedge clock);
         if (reset && wb_reg_en) begin
            if (exp_q.size() == 0) chk("spurious_write", 64'(wb_reg_en), 64'd0);
            else begin
               e = exp_q.pop_front();
               chk("wb_addr", 64'(wb_reg_addr), 64'(e.a));
               chk("wb_data", 64'(wb_reg_data), 64'(e.d));
            end
         end
      end
   end

   // One cycle: check pre-edge outputs, advance the model across the next edge, drive inputs.
   task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d);
      bit   rdy [3];
      bit   st;
      int   g, u;
      ent_t e;
      @(negedge clock);
      st = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rdy[i] = (mq[i].size() != DEPTH);
         if (mq[i].size() >= DEPTH - 1) st = 1'b1;
      end
      if (is_stall) stall_seen = 1'b1;
      chk("x_ready", 64'(x_ready), 64'(rdy[0]));
      chk("y_ready", 64'(y_ready), 64'(rdy[1]));
      chk("m_ready", 64'(m_ready), 64'(rdy[2]));
      chk("is_stall", 64'(is_stall), 64'(st));
      chk("wb_reg_en", 64'(wb_reg_en), 64'(exp_en));
      g = -1;
      for (int k = 0; k < 3; k++) begin
         u = (rr + k) % 3;
         if (g < 0 && mq[u].size() > 0) g = u;
      end
      if (g >= 0) begin
         exp_q.push_back(mq[g].pop_front());
         rr     = (g + 1) % 3;
         exp_en = 1'b1;
      end else exp_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e.a = a[i*5 +: 5];
         e.d = d[i*32 +: 32];
         if (v[i] && rdy[i] && e.a != 5'd0) mq[i].push_back(e);
      end
      x_wb_writereg = v[0]; x_wb_regdest = a[4:0];   x_wb_wbvalue = d[31:0];
      y_wb_writereg = v[1]; y_wb_regdest = a[9:5];   y_wb_wbvalue = d[63:32];
      m_wb_writereg = v[2]; m_wb_regdest = a[14:10]; m_wb_wbvalue = d[95:64];
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      reset = 1'b0;
      x_wb_writereg = 1'b0; y_wb_writereg = 1'b0; m_wb_writereg = 1'b0;
      for (int i = 0; i < 3; i++) mq[i].delete();
      exp_q.delete();
      rr     = 0;
      exp_en = 1'b0;
      @(negedge clock);
      #1;
      chk("rst_en", 64'(wb_reg_en), 64'd0);
      chk("rst_addr", 64'(wb_reg_addr), 64'd0);
      chk("rst_ready", 64'({x_ready, y_ready, m_ready}), 64'b111);
      chk("rst_stall", 64'(is_stall), 64'd0);
      reset = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (mq[0].size() + mq[1].size() + mq[2].size() + exp_q.size()) > 0; i++)
         step(3'b000, 15'd0, 96'd0);
      step(3'b000, 15'd0, 96'd0);
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [14:0] ra;
      logic [95:0] rd;
      tests = 0; fails = 0; rr = 0; exp_en = 1'b0; stall_seen = 1'b0;
      reset = 1'b1;
      x_wb_writereg = 1'b0; x_wb_regdest = '0; x_wb_wbvalue = '0;
      y_wb_writereg = 1'b0; y_wb_regdest = '0; y_wb_wbvalue = '0;
      m_wb_writereg = 1'b0; m_wb_regdest = '0; m_wb_wbvalue = '0;
      do_reset();

      // Reset with two entries queued: nothing must come out afterwards.
      step(3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'hA1});
      step(3'b001, {5'd0, 5'd0, 5'd8}, {32'd0, 32'd0, 32'hA2});
      do_reset();
      repeat (3) step(3'b000, 15'd0, 96'd0);

      // Single X write r3 = 0x11.
      step(3'b001, {5'd0, 5'd0, 5'd3}, {32'd0, 32'd0, 32'h11});
      drain();

      // Three units same edge from rr_ptr=X: r1, r2, r4 in order.
      do_reset();
      step(3'b111, {5'd4, 5'd2, 5'd1}, {32'h44, 32'h22, 32'h11});
      repeat (5) step(3'b000, 15'd0, 96'd0);
`ifdef WB_STATS_EN
      @(negedge clock);
      chk("stat_writes", 64'(stat_writes), 64'd3);
      chk("stat_conflicts", 64'(stat_conflicts), 64'd2);
`endif
      drain();

      // Continuous X and M pushes: stall must rise.
      stall_seen = 1'b0;
      for (int i = 0; i < 10; i++)
         step(3'b101, {5'(10 + i), 5'd0, 5'(i + 1)}, {32'(i + 100), 32'd0, 32'(i)});
      chk("stall_seen", 64'(stall_seen), 64'd1);
      drain();

      // M write to r0 is swallowed.
      step(3'b100, {5'd0, 5'd0, 5'd0}, {32'hDEAD, 32'd0, 32'd0});
      repeat (3) step(3'b000, 15'd0, 96'd0);

      // Random traffic with one mid-stream reset.
      for (int n = 0; n < 400; n++) begin
         ra = 15'($urandom);
         rd = {$urandom, $urandom, $urandom};
         if (n == 200) do_reset();
         step(3'($urandom), ra, rd);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
